// File: rtl/pnser_arb_pkg.sv
// Shared constants and types for the packetizing-serializer arbiter slice.
// Frame markers are used by the serializer; the arbiter uses the state encoding.
package pnser_pkg;
   localparam logic [3:0] HEADER    = 4'b1101;
   localparam logic [3:0] FOOTER    = 4'b0101;
   localparam int         DW_DEF    = 32;
   localparam int         LW_DEF    = 5;
   localparam int         N_SRC_DEF = 4;

   typedef enum logic [1:0] {
      FILL = 2'b00,
      BUSY = 2'b01
   } arb_state_t;
endpackage

// File: rtl/pnser_arb_if.sv
// Source-request and serializer-load bundle between the arbiter and its environment.
// Handshake: a source holds req/dat/len until its one-cycle gnt; the stage only moves on a ser_ack_i pulse.
interface pnser_arb_if #(
   parameter int N_SRC = pnser_pkg::N_SRC_DEF,
   parameter int DW    = pnser_pkg::DW_DEF,
   parameter int LW    = pnser_pkg::LW_DEF,
   parameter int SW    = $clog2(N_SRC)
);
   import pnser_pkg::*;

   logic [N_SRC-1:0]    src_req_i;
   logic [N_SRC*DW-1:0] src_dat_i;
   logic [N_SRC*LW-1:0] src_len_i;
   logic [N_SRC-1:0]    src_gnt_o;
   logic [DW-1:0]       ser_dat_o;
   logic [LW-1:0]       ser_len_o;
   logic                ser_vld_o;
   logic [SW-1:0]       ser_src_o;
   logic                ser_ack_i;
   logic [15:0]         pkt_cnt_o;
   arb_state_t          dbg_state_o;

   modport master (
      input  src_req_i, src_dat_i, src_len_i, ser_ack_i,
      output src_gnt_o, ser_dat_o, ser_len_o, ser_vld_o, ser_src_o, pkt_cnt_o, dbg_state_o
   );

   modport slave (
      output src_req_i, src_dat_i, src_len_i, ser_ack_i,
      input  src_gnt_o, ser_dat_o, ser_len_o, ser_vld_o, ser_src_o, pkt_cnt_o, dbg_state_o
   );
endinterface

// File: rtl/pnser_arb_rr_pick.sv
// Rotate-priority picker: first requester after i_ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [SW-1:0] i_ptr,
   output logic [SW-1:0] o_win,
   output logic          o_any
);
   logic [SW-1:0] w_idx;
   logic          w_found;

   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      o_win   = '0;
      for (int i = 1; i <= N; i++) begin
         w_idx = SW'((int'(i_ptr) + i) % N);
         if (!w_found && i_req[w_idx]) begin
            o_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign o_any = w_found;
endmodule

// File: rtl/pnser_arb.sv
// Round-robin arbiter staging one {data,len} word for a shared serializer.
// The stage only changes on the edge closing an ack cycle; filler is staged when nobody requests.
module pnser_arb
   import pnser_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int DW    = 32,
   parameter int LW    = 5,
   parameter int BURST = 1
) (
   input logic         clk_i,
   input logic         rst_i,
   pnser_arb_if.master bus
);
   localparam int              SW         = $clog2(N_SRC);
   localparam int              BCW        = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BCW-1:0]  BURST_LAST = BCW'(BURST - 1);

   arb_state_t        r_state, w_state_nxt;
   logic [SW-1:0]     r_ptr;
   logic [BCW-1:0]    r_burst;
   logic [DW-1:0]     r_dat;
   logic [LW-1:0]     r_len;
   logic              r_vld;
   logic [SW-1:0]     r_src;
   logic [N_SRC-1:0]  r_gnt;
   logic [15:0]       r_cnt;

   logic [SW-1:0]     w_pick_win;
   logic              w_pick_any;
   logic              w_keep;
   logic              w_grant;
   logic [SW-1:0]     w_win;

   rr_pick #(.N(N_SRC), .SW(SW)) u_pick (
      .i_req (bus.src_req_i),
      .i_ptr (r_ptr),
      .o_win (w_pick_win),
      .o_any (w_pick_any)
   );

   // While BUSY, r_ptr is the owner of the staged word; it may keep the grant for BURST words.
   assign w_keep  = (r_state == BUSY) && bus.src_req_i[r_ptr] && (r_burst != BURST_LAST);
   assign w_grant = w_keep | w_pick_any;
   assign w_win   = w_keep ? r_ptr : w_pick_win;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= FILL;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.ser_ack_i) w_state_nxt = w_grant ? BUSY : FILL;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr   <= SW'(N_SRC - 1);
         r_burst <= '0;
         r_dat   <= '0;
         r_len   <= '0;
         r_vld   <= 1'b0;
         r_src   <= '0;
         r_gnt   <= '0;
         r_cnt   <= '0;
      end else begin
         r_gnt <= '0;
         if (bus.ser_ack_i) begin
            if (r_state == BUSY) r_cnt <= r_cnt + 16'd1;
            if (w_grant) begin
               r_dat        <= bus.src_dat_i[w_win*DW +: DW];
               r_len        <= bus.src_len_i[w_win*LW +: LW];
               r_vld        <= 1'b1;
               r_src        <= w_win;
               r_gnt[w_win] <= 1'b1;
               r_ptr        <= w_win;
               r_burst      <= w_keep ? r_burst + 1'b1 : '0;
            end else begin
               r_dat   <= '0;
               r_len   <= '0;
               r_vld   <= 1'b0;
               r_src   <= '0;
               r_burst <= '0;
            end
         end
      end
   end

   assign bus.src_gnt_o   = r_gnt;
   assign bus.ser_dat_o   = r_dat;
   assign bus.ser_len_o   = r_len;
   assign bus.ser_vld_o   = r_vld;
   assign bus.ser_src_o   = r_src;
   assign bus.pkt_cnt_o   = r_cnt;
   assign bus.dbg_state_o = r_state;
endmodule

// File: tb/tb_pnser_arb.sv
// Bench for pnser_arb: one pure round-robin instance and one BURST=3 instance sharing the source inputs.
// Expected stage words are queued at each ack and compared one cycle later.
module tb_pnser_arb;
   import pnser_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  req  = '0;
   logic [31:0] sdat [4];
   logic [4:0]  slen [4];
   logic        ack1 = 1'b0;
   logic        ack3 = 1'b0;
   logic        done = 1'b0;

   pnser_arb_if #(.N_SRC(4), .DW(32), .LW(5)) b1 ();
   pnser_arb_if #(.N_SRC(4), .DW(32), .LW(5)) b3 ();

   assign b1.src_req_i = req;
   assign b1.src_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};
   assign b1.src_len_i = {slen[3], slen[2], slen[1], slen[0]};
   assign b1.ser_ack_i = ack1;
   assign b3.src_req_i = req;
   assign b3.src_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};
   assign b3.src_len_i = {slen[3], slen[2], slen[1], slen[0]};
   assign b3.ser_ack_i = ack3;

   pnser_arb #(.N_SRC(4), .DW(32), .LW(5), .BURST(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   pnser_arb #(.N_SRC(4), .DW(32), .LW(5), .BURST(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));

   // Word layout: gnt[59:56] vld[55] src[54:53] len[52:48] dat[47:16] cnt[15:0]
   localparam int W = 60;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_e [2];
   logic [15:0]  m_cnt  [2];
   bit           m_busy [2];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] obs_word(input int sel);
      if (sel == 0)
         return {b1.src_gnt_o, b1.ser_vld_o, b1.ser_src_o, b1.ser_len_o, b1.ser_dat_o, b1.pkt_cnt_o};
      return {b3.src_gnt_o, b3.ser_vld_o, b3.ser_src_o, b3.ser_len_o, b3.ser_dat_o, b3.pkt_cnt_o};
   endfunction

   task automatic cmp_word(input int sel, input logic [W-1:0] e);
      logic [W-1:0] o;
      logic [1:0]   st;
      o  = obs_word(sel);
      st = (sel == 0) ? b1.dbg_state_o : b3.dbg_state_o;
      chk(sel == 0 ? "d1_gnt" : "d3_gnt", 64'(o[59:56]), 64'(e[59:56]));
      chk(sel == 0 ? "d1_vld" : "d3_vld", 64'(o[55]),    64'(e[55]));
      chk(sel == 0 ? "d1_src" : "d3_src", 64'(o[54:53]), 64'(e[54:53]));
      chk(sel == 0 ? "d1_len" : "d3_len", 64'(o[52:48]), 64'(e[52:48]));
      chk(sel == 0 ? "d1_dat" : "d3_dat", 64'(o[47:16]), 64'(e[47:16]));
      chk(sel == 0 ? "d1_cnt" : "d3_cnt", 64'(o[15:0]),  64'(e[15:0]));
      chk(sel == 0 ? "d1_state" : "d3_state", 64'(st), e[55] ? 64'(BUSY) : 64'(FILL));
   endtask

   task automatic hold(input int sel, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         cmp_word(sel, last_e[sel]);
      end
   endtask

   // win < 0 means no requester is expected to win (filler staged).
   task automatic do_ack(input int sel, input int win, input int gap);
      logic [W-1:0] e;
      e = '0;
      if (m_busy[sel]) m_cnt[sel] = m_cnt[sel] + 16'd1;
      if (win >= 0) begin
         e[59:56] = 4'(1 << win);
         e[55]    = 1'b1;
         e[54:53] = 2'(win);
         e[52:48] = slen[win];
         e[47:16] = sdat[win];
      end
      e[15:0]     = m_cnt[sel];
      m_busy[sel] = (win >= 0);
      exp_q.push_back(e);
      if (sel == 0) ack1 = 1'b1;
      else          ack3 = 1'b1;
      @(posedge clk); #1;
      ack1 = 1'b0;
      ack3 = 1'b0;
      cmp_word(sel, exp_q.pop_front());
      last_e[sel]         = e;
      last_e[sel][59:56]  = '0;
      hold(sel, gap);
   endtask

   task automatic new_data();
      for (int i = 0; i < 4; i++) begin
         sdat[i] = $urandom;
         slen[i] = 5'($urandom_range(1, 31));
      end
   endtask

   // Reset lands mid-cycle so the outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      cmp_word(0, '0);
      cmp_word(1, '0);
      @(posedge clk); #1;
      cmp_word(0, '0);
      cmp_word(1, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_cnt[s]  = '0;
         m_busy[s] = 1'b0;
         last_e[s] = '0;
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst && !done) begin
         chk("d1_gnt_onehot", 64'($countones(b1.src_gnt_o) <= 1), 64'd1);
         chk("d3_gnt_onehot", 64'($countones(b3.src_gnt_o) <= 1), 64'd1);
      end
   end

   initial begin
      new_data();
      repeat (3) @(posedge clk);

      // First ack after reset stages source 0
      do_reset();
      req = 4'b0001;
      do_ack(0, 0, 3);
      do_ack(1, 0, 1);

      // Pure round robin with all sources requesting
      do_reset();
      new_data();
      req = 4'b1111;
      do_ack(0, 0, 2);
      do_ack(0, 1, 2);
      do_ack(0, 2, 2);
      do_ack(0, 3, 2);
      do_ack(0, 0, 2);
      do_ack(0, 1, 2);
      chk("rr_cnt5", 64'(b1.pkt_cnt_o), 64'd5);
      req = 4'b0000;
      do_ack(0, -1, 1);
      chk("busy_to_fill_cnt", 64'(b1.pkt_cnt_o), 64'd6);

      // Idle: filler only, counter untouched
      do_reset();
      req = 4'b0000;
      for (int k = 0; k < 3; k++) do_ack(0, -1, 1);
      for (int k = 0; k < 3; k++) do_ack(1, -1, 1);
      chk("idle_cnt", 64'(b1.pkt_cnt_o), 64'd0);

      // Stage stability: a request raised between acks must not disturb the stage
      do_reset();
      new_data();
      req = 4'b0001;
      do_ack(0, 0, 2);
      req = 4'b0100;
      hold(0, 3);
      req = 4'b0000;
      hold(0, 1);
      req = 4'b0100;
      do_ack(0, 2, 2);
      chk("stable_src2", 64'(b1.ser_src_o), 64'd2);

      // Burst of 3 per owner, then owner drops its request
      do_reset();
      new_data();
      req = 4'b1010;
      do_ack(1, 1, 1);
      do_ack(1, 1, 1);
      do_ack(1, 1, 1);
      do_ack(1, 3, 1);
      do_ack(1, 3, 1);
      do_ack(1, 3, 1);
      do_ack(1, 1, 1);
      req = 4'b1000;
      do_ack(1, 3, 1);
      chk("burst_cnt", 64'(b3.pkt_cnt_o), 64'd7);

      // Back-to-back acks on consecutive cycles
      do_reset();
      new_data();
      req = 4'b0110;
      do_ack(0, 1, 0);
      do_ack(0, 2, 0);
      req = 4'b0000;
      do_ack(0, -1, 2);

      // Reset with a real word staged discards it
      req = 4'b0001;
      do_ack(0, 0, 1);
      do_reset();

      // Packet counter wrap
      new_data();
      req = 4'b0001;
      do_ack(0, 0, 0);
      while (m_cnt[0] != 16'hFFFF) do_ack(0, 0, 0);
      chk("pre_wrap", 64'(b1.pkt_cnt_o), 64'hFFFF);
      do_ack(0, 0, 1);
      chk("wrap_zero", 64'(b1.pkt_cnt_o), 64'd0);

      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
